// File: rtl/bytes_avail_ctrl.sv
// rtl/bytes_avail_ctrl.sv - credit controller feeding the keep-masker's bytes-available input.
// Optional statistics ports (dropped_bytes, flush_count) enabled by BYTES_AVAIL_CTRL_STATS_EN.
module bytes_avail_ctrl #(
  parameter int BUSBYTEWIDTH = 16,
  parameter int BYTESAVAIL   = 32,
  parameter int PIPE_LAT     = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               businvld,
  input  logic [BUSBYTEWIDTH-1:0]            businkeep,
  input  logic                               drain_vld,
  input  logic [$clog2(BYTESAVAIL+1)-1:0]    drain_bytes,
  input  logic                               flush,
  output logic [$clog2(BYTESAVAIL+1)-1:0]    bytesavailout,
  output logic                               full,
  output logic                               flushing,
  output logic                               flush_done,
  output logic                               err_overflow
`ifdef BYTES_AVAIL_CTRL_STATS_EN
  ,
  output logic [31:0]                        dropped_bytes,
  output logic [15:0]                        flush_count
`endif
);

  localparam int AW = $clog2(BYTESAVAIL + 1);
  localparam int PW = $clog2(BUSBYTEWIDTH + 1);
  localparam int GW = (PW > AW + 1) ? PW : AW + 1;
  localparam int CW = $clog2(PIPE_LAT + 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FULL  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t          state, nxt_state;
  logic [AW-1:0]   avail, nxt_avail;
  logic [CW-1:0]   cnt, nxt_cnt;
  logic            nxt_err;
  logic [GW-1:0]   pop, grant, sum;

  // Bytes the masker keeps this beat: it clips the keep vector to the offered credit.
  always_comb begin
    pop = '0;
    for (int i = 0; i < BUSBYTEWIDTH; i++) begin
      pop = pop + GW'(businkeep[i]);
    end
    grant = '0;
    if (businvld) begin
      grant = (pop < GW'(bytesavailout)) ? pop : GW'(bytesavailout);
    end
    sum = GW'(avail) - grant + (drain_vld ? GW'(drain_bytes) : '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= RUN;
      avail        <= AW'(BYTESAVAIL);
      cnt          <= '0;
      err_overflow <= 1'b0;
    end else begin
      state        <= nxt_state;
      avail        <= nxt_avail;
      cnt          <= nxt_cnt;
      err_overflow <= nxt_err;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_avail = avail;
    nxt_cnt   = cnt;
    nxt_err   = err_overflow;
    if (flush) begin
      nxt_state = FLUSH;
      nxt_cnt   = CW'(PIPE_LAT - 1);
    end else begin
      case (state)
        FLUSH: begin
          if (cnt == '0) begin
            nxt_state = RUN;
            nxt_avail = AW'(BYTESAVAIL);
          end else begin
            nxt_cnt = cnt - 1'b1;
          end
        end
        default: begin
          if (sum > GW'(BYTESAVAIL)) begin
            nxt_avail = AW'(BYTESAVAIL);
            nxt_err   = 1'b1;
          end else begin
            nxt_avail = sum[AW-1:0];
          end
          nxt_state = (nxt_avail == '0) ? FULL : RUN;
        end
      endcase
    end
  end

  // Credit is withheld for the whole flush so nothing new enters the masker pipeline.
  always_comb begin
    bytesavailout = (state == FLUSH) ? '0 : avail;
    full          = (state == FULL);
    flushing      = (state == FLUSH);
    flush_done    = (state == FLUSH) && (cnt == '0);
  end

`ifdef BYTES_AVAIL_CTRL_STATS_EN
  logic [GW-1:0] drop;
  logic [32:0]   drop_sum;

  always_comb begin
    drop     = businvld ? (pop - (flush ? '0 : grant)) : '0;
    drop_sum = {1'b0, dropped_bytes} + 33'(drop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dropped_bytes <= '0;
      flush_count   <= '0;
    end else begin
      dropped_bytes <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
      if (flush) begin
        flush_count <= flush_count + 16'd1;
      end
    end
  end
`endif

endmodule
